// File: rtl/ex_mem_pkg.sv
// Shared types and constants for the EX/MEM pipeline stage.
// Holds branch funct3 encodings, the registered stage record and the epoch FSM states.
package ex_mem_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  typedef enum logic {
    E0 = 1'b0,
    E1 = 1'b1
  } epoch_state_t;

  typedef struct packed {
    logic [XLEN-1:0] result;
    logic [XLEN-1:0] rs2_data;
    logic [RA_W-1:0] rd;
    logic [2:0]      funct3;
    logic            mem_read;
    logic            mem_write;
    logic            reg_write;
    logic            exc;
  } ex_mem_t;

endpackage

// File: rtl/ex_mem_branch_cond.sv
// Branch resolution from the ALU zero flag; the decoder picks SUB/SLT/SLTU
// so every supported condition reduces to zero or not-zero.
module branch_cond
  import ex_mem_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       alu_zero,
  input  logic       is_branch,
  output logic       taken
);

  always_comb begin
    taken = 1'b0;
    if (is_branch) begin
      case (funct3)
        F3_BEQ, F3_BGE, F3_BGEU: taken = alu_zero;
        F3_BNE, F3_BLT, F3_BLTU: taken = !alu_zero;
        default:                 taken = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM boundary register with branch/jump resolution, one-cycle redirect and epoch tracking.
// Optional MISALIGN_CHECK_EN flags redirect targets with bit 1 set instead of redirecting.
//
// state | meaning
// E0    | epoch bit 0: fetch tags current-path instructions with 0
// E1    | epoch bit 1: fetch tags current-path instructions with 1
module ex_mem_stage
  import ex_mem_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic            in_epoch,
  input  logic [XLEN-1:0] alu_out,
  input  logic            alu_zero,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [RA_W-1:0] rd,
  input  logic [2:0]      funct3,
  input  logic            is_branch,
  input  logic            is_jal,
  input  logic            is_jalr,
  input  logic            mem_read,
  input  logic            mem_write,
  input  logic            reg_write,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [RA_W-1:0] out_rd,
  output logic [2:0]      out_funct3,
  output logic            out_mem_read,
  output logic            out_mem_write,
  output logic            out_reg_write,
  output logic            out_exc,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            epoch,
  input  logic            flush
);

  epoch_state_t    state_q, state_d;
  ex_mem_t         stage_q, stage_d;
  logic            taken;
  logic            accept;
  logic            current;
  logic            load;
  logic            redirecting;
  logic            misalign;
  logic            do_redirect;
  logic [XLEN-1:0] link_pc;
  logic [XLEN-1:0] branch_tgt;
  logic [XLEN-1:0] target;

  branch_cond u_branch_cond (
    .funct3    (funct3),
    .alu_zero  (alu_zero),
    .is_branch (is_branch),
    .taken     (taken)
  );

  assign epoch       = (state_q == E1);
  assign in_ready    = !out_valid || out_ready;
  assign accept      = in_valid && in_ready && !flush;
  assign current     = (in_epoch == epoch);
  assign load        = accept && current;

  assign link_pc     = pc + PC_INC;
  assign branch_tgt  = pc + imm;
  assign target      = is_jalr ? {alu_out[XLEN-1:1], 1'b0} : branch_tgt;
  assign redirecting = taken || is_jal || is_jalr;

`ifdef MISALIGN_CHECK_EN
  assign misalign    = redirecting && target[1];
`else
  assign misalign    = 1'b0;
`endif

  assign do_redirect = load && redirecting && !misalign;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= E0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      E0:      if (do_redirect) state_d = E1;
      E1:      if (do_redirect) state_d = E0;
      default: state_d = E0;
    endcase
  end

  // A trapped instruction still flows down so the exception can be taken, but with side effects squashed.
  always_comb begin
    stage_d           = '0;
    stage_d.result    = (is_jal || is_jalr) ? link_pc : alu_out;
    stage_d.rs2_data  = rs2_data;
    stage_d.rd        = rd;
    stage_d.funct3    = funct3;
    stage_d.mem_read  = mem_read && !misalign;
    stage_d.mem_write = mem_write && !misalign;
    stage_d.reg_write = reg_write && !misalign;
    stage_d.exc       = misalign;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid      <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      stage_q        <= '0;
    end else begin
      redirect_valid <= do_redirect;
      if (do_redirect) begin
        redirect_pc <= target;
      end
      if (flush) begin
        out_valid <= 1'b0;
      end else if (accept) begin
        out_valid <= current;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      if (load) begin
        stage_q <= stage_d;
      end
    end
  end

  assign out_result    = stage_q.result;
  assign out_rs2_data  = stage_q.rs2_data;
  assign out_rd        = stage_q.rd;
  assign out_funct3    = stage_q.funct3;
  assign out_mem_read  = stage_q.mem_read;
  assign out_mem_write = stage_q.mem_write;
  assign out_reg_write = stage_q.reg_write;
  assign out_exc       = stage_q.exc;

endmodule

// File: tb/tb_ex_mem_stage.sv
// Self-checking bench for ex_mem_stage: directed sequences, a vector table and a
// randomized run against an operand-level reference model (MISALIGN_CHECK_EN aware).
module tb_ex_mem_stage;
  import ex_mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_epoch;
  logic [31:0] alu_out, pc, imm, rs2_data;
  logic        alu_zero;
  logic [4:0]  rd;
  logic [2:0]  funct3;
  logic        is_branch, is_jal, is_jalr, mem_read, mem_write, reg_write;
  logic        out_valid, out_ready;
  logic [31:0] out_result, out_rs2_data;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic        out_mem_read, out_mem_write, out_reg_write, out_exc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        epoch, flush;

  always #5 clk = ~clk;

  ex_mem_stage dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_epoch(in_epoch),
    .alu_out(alu_out), .alu_zero(alu_zero), .pc(pc), .imm(imm), .rs2_data(rs2_data), .rd(rd),
    .funct3(funct3), .is_branch(is_branch), .is_jal(is_jal), .is_jalr(is_jalr),
    .mem_read(mem_read), .mem_write(mem_write), .reg_write(reg_write),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_rs2_data(out_rs2_data), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_reg_write(out_reg_write),
    .out_exc(out_exc), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .epoch(epoch), .flush(flush)
  );

  int   n_cmp = 0;
  int   n_err = 0;
  logic exp_epoch;

  typedef struct {
    logic [31:0] pc, imm, alu;
    logic [2:0]  f3;
    logic        br, jal, jalr, rw;
    logic [31:0] exp_res;
    logic        exp_redir;
    logic [31:0] exp_rpc;
    logic        exp_exc;
  } vec_t;

  vec_t vecs[13];

  function automatic vec_t mk(input logic [31:0] p, input logic [31:0] i, input logic [31:0] a,
                              input logic [2:0] f, input logic b, input logic j, input logic jr,
                              input logic w, input logic [31:0] res, input logic rdr,
                              input logic [31:0] rpc, input logic ex);
    vec_t v;
    v.pc = p; v.imm = i; v.alu = a; v.f3 = f; v.br = b; v.jal = j; v.jalr = jr; v.rw = w;
    v.exp_res = res; v.exp_redir = rdr; v.exp_rpc = rpc; v.exp_exc = ex;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; in_epoch = exp_epoch;
    is_branch = 0; is_jal = 0; is_jalr = 0;
    mem_read = 0; mem_write = 0; reg_write = 0;
    funct3 = 0; alu_out = 0; alu_zero = 1; pc = 0; imm = 0; rs2_data = 0; rd = 0;
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] i, input logic [31:0] a,
                       input logic [2:0] f, input logic b, input logic j, input logic jr,
                       input logic w);
    in_valid = 1; in_epoch = exp_epoch; flush = 0;
    pc = p; imm = i; alu_out = a; alu_zero = (a == 32'd0); funct3 = f;
    is_branch = b; is_jal = j; is_jalr = jr; reg_write = w;
    mem_read = 0; mem_write = 0; rs2_data = 32'hA5A5_0000 ^ p; rd = 5'd7;
  endtask

  // reference model state
  logic        m_valid, m_rv, m_epoch;
  logic [31:0] m_res, m_rs2, m_rpc;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic        m_mr, m_mw, m_rw, m_exc;

  initial begin
    rst_n = 0; out_ready = 1; exp_epoch = 0;
    idle();
    #12;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk1("rst_redirect_valid", redirect_valid, 1'b0);
    chk1("rst_out_exc", out_exc, 1'b0);
    chk1("rst_epoch", epoch, 1'b0);
    chk("rst_out_result", out_result, 32'h0);
    chk("rst_redirect_pc", redirect_pc, 32'h0);
    chk1("rst_in_ready", in_ready, 1'b1);
    rst_n = 1;
    step();

    // pipelined ADD stream
    drive(32'h10, 0, 32'd5, 3'b000, 0, 0, 0, 1);
    step();
    drive(32'h14, 0, 32'd7, 3'b000, 0, 0, 0, 1);
    chk("add0_result", out_result, 32'd5); chk1("add0_valid", out_valid, 1'b1);
    chk1("add0_redir", redirect_valid, 1'b0);
    step();
    drive(32'h18, 0, 32'd9, 3'b000, 0, 0, 0, 1);
    chk("add1_result", out_result, 32'd7); chk1("add1_valid", out_valid, 1'b1);
    step();
    idle();
    chk("add2_result", out_result, 32'd9); chk1("add2_valid", out_valid, 1'b1);
    chk1("add2_redir", redirect_valid, 1'b0);
    step();
    chk1("add_drain", out_valid, 1'b0);

    // BEQ taken, then a stale instruction
    drive(32'h100, 32'h20, 32'd0, F3_BEQ, 1, 0, 0, 0);
    step();
    drive(32'h200, 0, 32'h55, 3'b000, 0, 0, 0, 1);
    in_epoch = 1'b0;
    chk1("beq_redir", redirect_valid, 1'b1); chk("beq_rpc", redirect_pc, 32'h120);
    chk1("beq_epoch", epoch, 1'b1); chk1("beq_valid", out_valid, 1'b1);
    step();
    idle();
    exp_epoch = 1; in_epoch = 1;
    chk1("stale_valid", out_valid, 1'b0); chk1("stale_redir", redirect_valid, 1'b0);
    chk1("stale_epoch", epoch, 1'b1);
    step();

    // BNE taken held under backpressure
    out_ready = 0;
    drive(32'h80, 32'h10, 32'd1, F3_BNE, 1, 0, 0, 0);
    step();
    drive(32'h300, 0, 32'h99, 3'b000, 0, 0, 0, 1);
    in_epoch = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk1("stall_redir", redirect_valid, (i == 0));
      chk1("stall_valid", out_valid, 1'b1);
      chk1("stall_in_ready", in_ready, 1'b0);
      chk("stall_result", out_result, 32'd1);
      chk("stall_rpc", redirect_pc, 32'h90);
      chk1("stall_epoch", epoch, 1'b0);
      step();
    end
    exp_epoch = 0;
    idle();
    out_ready = 1;
    step();
    chk1("stall_drain", out_valid, 1'b0);

    // flush coincident with JAL
    drive(32'h700, 32'h10, 32'd0, 3'b000, 0, 1, 0, 1);
    flush = 1;
    step();
    idle();
    chk1("flush_valid", out_valid, 1'b0); chk1("flush_redir", redirect_valid, 1'b0);
    chk1("flush_epoch", epoch, 1'b0);
    step();

    // vector table
    vecs[0]  = mk(32'h10, 0, 32'd5, 3'b000, 0, 0, 0, 1, 32'd5, 0, 0, 0);
    vecs[1]  = mk(32'h100, 32'h20, 0, F3_BEQ, 1, 0, 0, 0, 32'd0, 1, 32'h120, 0);
    vecs[2]  = mk(32'h104, 32'h20, 32'd3, F3_BEQ, 1, 0, 0, 0, 32'd3, 0, 0, 0);
    vecs[3]  = mk(32'h200, 32'hFFFF_FFF0, 32'd7, F3_BNE, 1, 0, 0, 0, 32'd7, 1, 32'h1F0, 0);
    vecs[4]  = mk(32'h300, 32'd8, 0, F3_BLT, 1, 0, 0, 0, 32'd0, 0, 0, 0);
    vecs[5]  = mk(32'h300, 32'd8, 0, F3_BGE, 1, 0, 0, 0, 32'd0, 1, 32'h308, 0);
    vecs[6]  = mk(32'h400, 32'h40, 32'd1, F3_BLTU, 1, 0, 0, 0, 32'd1, 1, 32'h440, 0);
    vecs[7]  = mk(32'h400, 32'h40, 32'd1, F3_BGEU, 1, 0, 0, 0, 32'd1, 0, 0, 0);
    vecs[8]  = mk(32'h500, 32'h10, 0, 3'b010, 1, 0, 0, 0, 32'd0, 0, 0, 0);
    vecs[9]  = mk(32'h500, 32'h10, 32'd1, 3'b011, 1, 0, 0, 0, 32'd1, 0, 0, 0);
    vecs[10] = mk(32'h40, 0, 32'h2005, 3'b000, 0, 0, 1, 1, 32'h44, 1, 32'h2004, 0);
    vecs[11] = mk(32'hFFFF_FFFC, 32'd8, 32'h1234, 3'b000, 0, 1, 0, 1, 32'h0, 1, 32'h4, 0);
`ifdef MISALIGN_CHECK_EN
    vecs[12] = mk(32'h0, 32'h6, 0, 3'b000, 0, 1, 0, 1, 32'h4, 0, 0, 1);
`else
    vecs[12] = mk(32'h0, 32'h6, 0, 3'b000, 0, 1, 0, 1, 32'h4, 1, 32'h6, 0);
`endif
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].pc, vecs[i].imm, vecs[i].alu, vecs[i].f3, vecs[i].br, vecs[i].jal,
            vecs[i].jalr, vecs[i].rw);
      step();
      idle();
      if (vecs[i].exp_redir) exp_epoch = !exp_epoch;
      chk1($sformatf("vec%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("vec%0d_result", i), out_result, vecs[i].exp_res);
      chk1($sformatf("vec%0d_redir", i), redirect_valid, vecs[i].exp_redir);
      if (vecs[i].exp_redir) chk($sformatf("vec%0d_rpc", i), redirect_pc, vecs[i].exp_rpc);
      chk1($sformatf("vec%0d_exc", i), out_exc, vecs[i].exp_exc);
      chk1($sformatf("vec%0d_rw", i), out_reg_write, vecs[i].rw && !vecs[i].exp_exc);
      chk1($sformatf("vec%0d_epoch", i), epoch, exp_epoch);
      in_epoch = exp_epoch;
    end
    step();

    // asynchronous reset while an instruction is held
    out_ready = 0;
    drive(32'h900, 0, 32'h77, 3'b000, 0, 0, 0, 1);
    step();
    idle();
    chk1("hold_valid", out_valid, 1'b1);
    rst_n = 0;
    #1;
    chk1("arst_valid", out_valid, 1'b0);
    chk("arst_result", out_result, 32'h0);
    chk1("arst_epoch", epoch, 1'b0);
    chk1("arst_in_ready", in_ready, 1'b1);
    step();
    rst_n = 1;
    exp_epoch = 0;
    out_ready = 1;
    idle();
    step();

    // randomized run against the reference model
    m_valid = 0; m_rv = 0; m_epoch = 0;
    m_res = 0; m_rs2 = 0; m_rpc = 0; m_rd = 0; m_f3 = 0;
    m_mr = 0; m_mw = 0; m_rw = 0; m_exc = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      int          kind;
      logic [31:0] a, b, tgt;
      logic        tk, redir, mis, rdy, acc, cur;
      kind = $urandom_range(0, 3);
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? a : $urandom;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 15) == 0);
      in_epoch  = ($urandom_range(0, 7) == 0) ? !m_epoch : m_epoch;
      pc  = $urandom & ~32'd3;
      imm = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & ~32'd3);
      funct3 = 3'($urandom_range(0, 7));
      is_branch = (kind == 1); is_jal = (kind == 2); is_jalr = (kind == 3);
      mem_read = 1'($urandom_range(0, 1)); mem_write = 1'($urandom_range(0, 1));
      reg_write = 1'($urandom_range(0, 1));
      rd = 5'($urandom_range(0, 31)); rs2_data = $urandom;
      tk = 1'b0;
      if (kind == 1) begin
        case (funct3)
          3'b000: begin alu_out = a - b; tk = (a == b); end
          3'b001: begin alu_out = a - b; tk = (a != b); end
          3'b100: begin alu_out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        tk = ($signed(a) < $signed(b)); end
          3'b101: begin alu_out = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
                        tk = ($signed(a) >= $signed(b)); end
          3'b110: begin alu_out = (a < b) ? 32'd1 : 32'd0; tk = (a < b); end
          3'b111: begin alu_out = (a < b) ? 32'd1 : 32'd0; tk = (a >= b); end
          default: alu_out = ($urandom_range(0, 1) == 0) ? 32'd0 : a;
        endcase
      end else begin
        alu_out = ($urandom_range(0, 7) == 0) ? 32'd0 : a;
      end
      alu_zero = (alu_out == 32'd0);
      redir = tk || is_jal || is_jalr;
      tgt = is_jalr ? (alu_out & ~32'd1) : (pc + imm);
`ifdef MISALIGN_CHECK_EN
      mis = redir && tgt[1];
`else
      mis = 1'b0;
`endif
      #1;
      rdy = !m_valid || out_ready;
      chk1("rnd_in_ready", in_ready, rdy);
      acc = in_valid && rdy && !flush;
      cur = (in_epoch == m_epoch);
      step();
      if (flush) begin
        m_valid = 0; m_rv = 0;
      end else if (acc) begin
        m_valid = cur;
        m_rv = cur && redir && !mis;
        if (cur) begin
          m_res = (is_jal || is_jalr) ? pc + 32'd4 : alu_out;
          m_rs2 = rs2_data; m_rd = rd; m_f3 = funct3;
          m_mr = mem_read && !mis; m_mw = mem_write && !mis; m_rw = reg_write && !mis;
          m_exc = mis;
        end
        if (m_rv) begin
          m_rpc = tgt; m_epoch = !m_epoch;
        end
      end else begin
        m_rv = 0;
        if (out_ready) m_valid = 0;
      end
      chk1("rnd_valid", out_valid, m_valid);
      chk1("rnd_redir", redirect_valid, m_rv);
      chk1("rnd_epoch", epoch, m_epoch);
      if (m_rv) chk("rnd_rpc", redirect_pc, m_rpc);
      if (m_valid) begin
        chk("rnd_result", out_result, m_res);
        chk("rnd_rs2", out_rs2_data, m_rs2);
        chk("rnd_rd", {27'd0, out_rd}, {27'd0, m_rd});
        chk("rnd_f3", {29'd0, out_funct3}, {29'd0, m_f3});
        chk1("rnd_mr", out_mem_read, m_mr);
        chk1("rnd_mw", out_mem_write, m_mw);
        chk1("rnd_rw", out_reg_write, m_rw);
        chk1("rnd_exc", out_exc, m_exc);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ex_mem_stage.md
# ex_mem_stage

Execute-to-memory pipeline stage placed directly downstream of the ALU. It consumes the ALU result and flags together with the decoded control fields, and resolves branches and jumps. It registers the instruction into the EX/MEM boundary behind a valid/ready handshake and issues a one-cycle PC redirect. Wrong-path instructions are discarded using a one-bit epoch.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register-address width
- clk  in  1  rising-edge clock
- rst_n  in  1  reset, asynchronous and active-low
- in_valid / in_ready  in/out  1  upstream handshake
- in_epoch  in  1  epoch tag the instruction was fetched under
- alu_out  in  XLEN  ALU result
- alu_zero  in  1  ALU Zero flag (alu_out == 0)
- pc, imm, rs2_data  in  XLEN  instruction PC, immediate, store data
- rd  in  RA_W  destination register
- funct3  in  3  branch condition / memory size
- is_branch, is_jal, is_jalr, mem_read, mem_write, reg_write  in  1  decoded control
- out_valid / out_ready  out/in  1  downstream handshake
- out_result  out  XLEN  alu_out, or pc+4 for jal/jalr
- out_rs2_data  out  XLEN  registered store data
- out_rd  out  RA_W  registered destination register
- out_funct3  out  3  registered funct3
- out_mem_read, out_mem_write, out_reg_write  out  1  registered control
- out_exc  out  1  misaligned-target exception flag
- redirect_valid  out  1  one-cycle redirect pulse
- redirect_pc  out  XLEN  redirect target
- epoch  out  1  current epoch, fed back to fetch
- flush  in  1  kill from later stages

## Operation
- in_ready = !out_valid || out_ready. An input is accepted when in_valid && in_ready && !flush.
- Stale input: an accepted input whose in_epoch != epoch is dropped. The input is consumed, out_valid is 0 next cycle, and there is no redirect.
- The decoder sets the ALU operation for branches: SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
- Branch taken conditions:
  - BEQ taken = alu_zero; BNE taken = !alu_zero.
  - BLT and BLTU taken = !alu_zero.
  - BGE and BGEU taken = alu_zero.
  - funct3 010 or 011 with is_branch = never taken.
- Targets:
  - Taken branch and jal: pc + imm, modulo 2^XLEN.
  - jalr: alu_out with bit 0 cleared.
- out_result = pc + 4 (wraps modulo 2^XLEN) for jal/jalr, else alu_out.
- On acceptance of a current-epoch redirecting instruction (taken branch, jal, jalr):
  - redirect_valid = 1 and redirect_pc = target, for exactly one cycle.
  - epoch toggles in that same cycle.
- Epoch state machine, two states (E0, E1):
  - Redirect acceptance moves E0→E1 and E1→E0.
  - Reset enters E0.
  - flush does not change epoch.
- Flush:
  - out_valid and redirect_valid are forced to 0 next cycle.
  - No acceptance in the flush cycle.
  - flush wins over a simultaneous accept or redirect.
- Stall: while out_valid && !out_ready, all out_* fields hold and in_ready is 0.

## Timing
- Latency is 1 cycle, acceptance edge to out_valid.
- redirect_valid is coincident with out_valid of the same instruction. It does not repeat if out_ready stays low.
- Full throughput: one instruction per cycle when out_ready = 1.
- Reset values:
  - out_valid, redirect_valid, out_exc, epoch = 0.
  - All out_* data/control fields and redirect_pc = 0.
  - in_ready = 1 after reset.
- rst_n assertion mid-stall drops the held instruction immediately (asynchronous).

## Configuration
- MISALIGN_CHECK_EN defined:
  - Condition: a redirecting instruction whose target[1] = 1.
  - Effect: registered with out_exc = 1, out_reg_write = 0, out_mem_write = 0, out_mem_read = 0.
  - No redirect and no epoch toggle.
- MISALIGN_CHECK_EN undefined: no target check; out_exc is tied 0; redirect proceeds with the target as computed.

## Structure
- Shared package ex_mem_pkg holds:
  - funct3 branch constants (F3_BEQ…F3_BGEU).
  - Packed struct ex_mem_t carrying the registered out_* fields.
  - A localparam for the pc+4 increment.
- Sub-module branch_cond: combinational; takes funct3, alu_zero and is_branch, produces taken.

## Test plan
- Pipelined ADD stream (alu_out 5, 7, 9), out_ready = 1 → out_result 5, 7, 9 on consecutive cycles, no redirect.
- BEQ, pc = 0x100, imm = 0x20, alu_zero = 1 → redirect_pc = 0x120 pulse for 1 cycle, epoch 0→1. A following input with in_epoch = 0 is dropped.
- JALR, alu_out = 0x2005, pc = 0x40 → redirect_pc = 0x2004, out_result = 0x44, out_reg_write = 1.
- out_ready held 0 for 3 cycles after a BNE-taken → redirect_valid high 1 cycle only, out fields stable, in_ready = 0 throughout.
- flush in the same cycle as a JAL acceptance → no redirect, out_valid = 0, epoch unchanged.
- With MISALIGN_CHECK_EN, JAL pc = 0x0, imm = 0x6 → out_exc = 1, redirect_valid = 0, epoch unchanged. Without the macro → redirect_pc = 0x6.
